// File: rtl/conv_pkg.sv
// Shared constants and types for the 5x5 convolution datapath.
package conv_pkg;

    localparam int K        = 5;
    localparam int PIX_W    = 8;
    localparam int PROD_W   = 16;
    localparam int ROWSUM_W = 19;
    localparam int TREE_W   = 21;
    localparam int ACC_W    = 32;

    typedef logic signed [PIX_W-1:0]    pix_t;
    typedef pix_t [K-1:0][K-1:0]        window_t;
    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [ROWSUM_W-1:0] rowsum_t;
    typedef logic signed [TREE_W-1:0]   tree_t;

endpackage

// File: rtl/conv_pos_tracker.sv
// Raster position tracker: follows the pixel strobe through col/row and
// flags, one cycle later, whether the window around that pixel is complete
// and whether it was the last pixel of the frame.
module conv_pos_tracker #(
    parameter int LENGTH = 32,
    parameter int HEIGHT = 32,
    parameter int MARGIN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic data_valid_in,
    output logic s0_valid,
    output logic s0_last
);

    localparam int COL_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             s0_valid_q, s0_valid_d;
    logic             s0_last_q, s0_last_d;
    logic             col_end, row_end;

    assign col_end = (col_q == COL_W'(LENGTH - 1));
    assign row_end = (row_q == ROW_W'(HEIGHT - 1));

    // Next position and qualification of the pixel strobed this cycle.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        s0_valid_d = 1'b0;
        s0_last_d  = 1'b0;
        if (data_valid_in) begin
            s0_valid_d = (col_q >= COL_W'(MARGIN)) && (row_q >= ROW_W'(MARGIN));
            s0_last_d  = col_end && row_end;
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position and stage-A qualifier registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            s0_valid_q <= 1'b0;
            s0_last_q  <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s0_valid_q <= s0_valid_d;
            s0_last_q  <= s0_last_d;
        end
    end

    assign s0_valid = s0_valid_q;
    assign s0_last  = s0_last_q;

endmodule

// File: rtl/conv5x5_mac.sv
// 5x5 convolution MAC behind the line-buffer/window stage.
// Pipeline: stage A qualifier (tracker) -> products -> row sums -> result.
// Optional RELU_EN: clamp negative results to zero at the output stage.
module conv5x5_mac
    import conv_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int HEIGHT = 32
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    data_valid_in,
    input  window_t window,
    input  window_t weights,
    input  acc_t    bias,
    output acc_t    result,
    output logic    result_valid,
    output logic    frame_done
);

    logic    s0_valid, s0_last;
    logic    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic    result_valid_q, result_valid_d;
    logic    frame_done_q, frame_done_d;
    prod_t   prod_q   [K][K];
    prod_t   prod_d   [K][K];
    rowsum_t rowsum_q [K];
    rowsum_t rowsum_d [K];
    acc_t    result_q, result_d;
    tree_t   tree_sum;
    acc_t    sum_wide;

    conv_pos_tracker #(
        .LENGTH (LENGTH),
        .HEIGHT (HEIGHT),
        .MARGIN (K - 1)
    ) u_pos (
        .clk           (clk),
        .rst           (rst),
        .data_valid_in (data_valid_in),
        .s0_valid      (s0_valid),
        .s0_last       (s0_last)
    );

    // Valid/last qualifiers ride alongside the data through each stage.
    always_comb begin
        s1_valid_d     = s0_valid;
        s1_last_d      = s0_valid && s0_last;
        s2_valid_d     = s1_valid_q;
        s2_last_d      = s1_last_q;
        result_valid_d = s2_valid_q;
        frame_done_d   = s2_valid_q && s2_last_q;
    end

    // Stage 1: elementwise products; window and weights sampled here.
    always_comb begin
        prod_d = prod_q;
        if (s0_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod_d[r][c] = prod_t'(window[r][c]) * prod_t'(weights[r][c]);
                end
            end
        end
    end

    // Stage 2: one sum per kernel row.
    always_comb begin
        rowsum_d = rowsum_q;
        if (s1_valid_q) begin
            for (int r = 0; r < K; r++) begin
                rowsum_d[r] = '0;
                for (int c = 0; c < K; c++) begin
                    rowsum_d[r] = rowsum_d[r] + rowsum_t'(prod_q[r][c]);
                end
            end
        end
    end

    // Stage 3: total plus bias in 32-bit wrapping arithmetic; holds when idle.
    always_comb begin
        tree_sum = '0;
        for (int r = 0; r < K; r++) begin
            tree_sum = tree_sum + tree_t'(rowsum_q[r]);
        end
        sum_wide = acc_t'(tree_sum) + bias;
        result_d = result_q;
        if (s2_valid_q) begin
`ifdef RELU_EN
            result_d = sum_wide[ACC_W-1] ? '0 : sum_wide;
`else
            result_d = sum_wide;
`endif
        end
    end

    // Control registers: cleared by reset so in-flight results are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_last_q      <= 1'b0;
            result_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            result_q       <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_last_q      <= s1_last_d;
            s2_valid_q     <= s2_valid_d;
            s2_last_q      <= s2_last_d;
            result_valid_q <= result_valid_d;
            frame_done_q   <= frame_done_d;
            result_q       <= result_d;
        end
    end

    // Datapath registers: only meaningful when their stage valid is set.
    always_ff @(posedge clk) begin
        prod_q   <= prod_d;
        rowsum_q <= rowsum_d;
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv5x5_mac.sv
// Bench for conv5x5_mac: models the window stage from a stored frame image,
// keeps a scoreboard of expected results and checks value, cycle and
// frame_done of every output.
module tb_conv5x5_mac;
    import conv_pkg::*;

    localparam int L = 8;
    localparam int H = 8;

    logic    clk = 1'b0;
    logic    rst;
    logic    dv;
    window_t window;
    window_t weights;
    acc_t    bias;
    acc_t    result;
    logic    result_valid;
    logic    frame_done;

    always #5 clk = ~clk;

    conv5x5_mac #(.LENGTH(L), .HEIGHT(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_valid_in (dv),
        .window        (window),
        .weights       (weights),
        .bias          (bias),
        .result        (result),
        .result_valid  (result_valid),
        .frame_done    (frame_done)
    );

    typedef struct {
        int val;
        bit last;
        int cyc;
    } exp_t;

    exp_t    sb[$];
    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    int      nres;
    int      first_val;
    bit      mon_en;
    int      img [H][L];
    int      wt [K][K];
    int      bias_i;
    int      tr, tc;
    bit      pend;
    window_t pend_win;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int r0, input int c0);
        int s = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += img[r0-r][c0-4+c] * wt[r][c];
        s += bias_i;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // Output monitor: pops the scoreboard on every result, flags late/missing ones.
    always @(negedge clk) begin
        if (mon_en) begin
            if (result_valid) begin
                nres++;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (nres == 1) first_val = result;
                    chk("result_value", result, e.val);
                    chk("frame_done", frame_done, e.last);
                    chk("result_cycle", cyc, e.cyc);
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    chk("missing_result_at_cycle", cyc, -1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; the window for a strobed pixel appears the cycle after.
    task automatic step(input bit v);
        window_t w;
        @(negedge clk);
        if (pend) window = pend_win;
        pend = 0;
        dv = v;
        if (v) begin
            w = '0;
            if (tr >= 4 && tc >= 4) begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        w[r][c] = pix_t'(img[tr-r][tc-4+c]);
                sb.push_back('{model(tr, tc), (tr == H-1 && tc == L-1), cyc + 4});
            end
            pend_win = w;
            pend = 1;
            if (tc == L-1) begin
                tc = 0;
                tr = (tr == H-1) ? 0 : tr + 1;
            end else begin
                tc++;
            end
        end
    endtask

    task automatic run_pixels(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            step(1);
            if (toggle) step(0);
        end
    endtask

    task automatic drain();
        repeat (8) step(0);
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < L; c++)
                img[r][c] = v;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < L; c++)
                img[r][c] = r * L + c;
    endtask

    task automatic set_cfg(input int wv, input int b);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                wt[r][c] = wv;
        bias_i = b;
    endtask

    task automatic apply_cfg();
        @(negedge clk);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                weights[r][c] = pix_t'(wt[r][c]);
        bias = acc_t'(bias_i);
        nres = 0;
        first_val = 0;
    endtask

    task automatic end_frame(input string tag, input int n, input int first);
        chk({tag, "_count"}, nres, n);
        chk({tag, "_leftover"}, sb.size(), 0);
        chk({tag, "_first"}, first_val, first);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mon_en = 0;
        rst = 1;
        dv = 0;
        pend = 0;
        window = '0;
        sb.delete();
        tr = 0;
        tc = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 0;
        mon_en = 1;
    endtask

    initial begin
        rst = 1; dv = 0; window = '0; weights = '0; bias = '0;
        mon_en = 0; pend = 0; tr = 0; tc = 0; nres = 0; first_val = 0;
        do_reset();

        // All ones: 25 per result, 16 results, frame_done on the last.
        fill_const(1); set_cfg(1, 0); apply_cfg();
        run_pixels(L*H, 0); drain();
        end_frame("ones", 16, 25);

        // Two frames back to back: the wrap and the next pixel share an edge.
        apply_cfg();
        run_pixels(2*L*H, 0); drain();
        end_frame("b2b", 32, 25);

        // Ramp through the newest pixel (window[0][4]): result = pixel index.
        fill_ramp(); set_cfg(0, 0); wt[0][4] = 1; apply_cfg();
        run_pixels(L*H, 0); drain();
        end_frame("ramp", 16, 36);

        // Extreme negatives: 25*16384 - 1.
        fill_const(-128); set_cfg(-128, -1); apply_cfg();
        run_pixels(L*H, 0); drain();
        end_frame("neg128", 16, 409599);

        // Negative sum: raw, or clamped with RELU_EN.
        fill_const(-5); set_cfg(1, 0); apply_cfg();
        run_pixels(L*H, 0); drain();
`ifdef RELU_EN
        end_frame("neg5", 16, 0);
`else
        end_frame("neg5", 16, -125);
`endif

        // Strobe gaps: same values and count, each result 4 cycles after its strobe.
        fill_ramp(); set_cfg(0, 0); wt[0][4] = 1; apply_cfg();
        run_pixels(L*H, 1); drain();
        end_frame("gaps", 16, 36);

        // Reset with results in flight, then a clean full frame.
        fill_const(1); set_cfg(1, 0); apply_cfg();
        run_pixels(44, 0);
        do_reset();
        apply_cfg();
        run_pixels(L*H, 0); drain();
        end_frame("after_rst", 16, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
